// File: rtl/dense_layer.sv
// Fully-connected layer: one signed MAC per cycle over the pooled activations, saturated Q-format logits out.
// Each neuron takes IN_DIM+1 cycles, done pulses one cycle after the last write; no backpressure.
module dense_layer #(
   parameter int DATA_WIDTH = 16,
   parameter int FRAC_BITS  = 7,
   parameter int IN_DIM     = 1568,
   parameter int OUT_DIM    = 10
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              start,
   output logic [$clog2(IN_DIM)-1:0]         in_addr,
   output logic                              in_en,
   input  logic signed [DATA_WIDTH-1:0]      in_q,
   output logic [$clog2(IN_DIM*OUT_DIM)-1:0] w_addr,
   output logic                              w_en,
   input  logic signed [DATA_WIDTH-1:0]      w_q,
   output logic [$clog2(OUT_DIM)-1:0]        b_addr,
   output logic                              b_en,
   input  logic signed [DATA_WIDTH-1:0]      b_q,
   output logic [$clog2(OUT_DIM)-1:0]        out_addr,
   output logic                              out_en,
   output logic                              out_we,
   output logic signed [DATA_WIDTH-1:0]      out_d,
   output logic                              busy,
   output logic                              done
);

   localparam int IW = $clog2(IN_DIM);
   localparam int WW = $clog2(IN_DIM*OUT_DIM);
   localparam int OW = $clog2(OUT_DIM);
   localparam int PW = 2*DATA_WIDTH;
   localparam int AW = PW + IW;

   localparam logic [IW-1:0] I_LAST = IW'(IN_DIM-1);
   localparam logic [OW-1:0] O_LAST = OW'(OUT_DIM-1);
   localparam logic signed [AW-1:0] SAT_HI = {{(AW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [AW-1:0] SAT_LO = {{(AW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
   localparam logic signed [DATA_WIDTH-1:0] D_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [DATA_WIDTH-1:0] D_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, MAC, WRITE, FINISH} state_t;

   state_t state, state_nxt;

   logic [IW-1:0]                i, i_nxt;
   logic [OW-1:0]                o, o_nxt;
   logic signed [AW-1:0]         acc, acc_nxt;
   logic signed [PW-1:0]         prod;
   logic signed [AW-1:0]         prod_ext, bias_ext, shifted;
   logic signed [DATA_WIDTH-1:0] sat_val;

   logic [IW-1:0]                in_addr_nxt;
   logic [WW-1:0]                w_addr_nxt;
   logic [OW-1:0]                b_addr_nxt, out_addr_nxt;
   logic signed [DATA_WIDTH-1:0] out_d_nxt;
   logic                         in_en_nxt, w_en_nxt, b_en_nxt, out_en_nxt, out_we_nxt, done_nxt;
   logic                         launch;

   assign prod     = in_q * w_q;
   assign prod_ext = {{IW{prod[PW-1]}}, prod};
   assign bias_ext = {{(AW-DATA_WIDTH-FRAC_BITS){b_q[DATA_WIDTH-1]}}, b_q, {FRAC_BITS{1'b0}}};
   assign shifted  = acc >>> FRAC_BITS;

   // A start still high while done pulses waits one cycle, so the controller sees done before the relaunch.
   assign launch = start && !done;

   always_comb begin
      if (shifted > SAT_HI)
         sat_val = D_MAX;
      else if (shifted < SAT_LO)
         sat_val = D_MIN;
      else
         sat_val = shifted[DATA_WIDTH-1:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (launch) state_nxt = MAC;
         MAC:     if (i == I_LAST) state_nxt = WRITE;
         WRITE:   state_nxt = (o == O_LAST) ? FINISH : MAC;
         FINISH:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      i_nxt        = i;
      o_nxt        = o;
      acc_nxt      = acc;
      in_addr_nxt  = in_addr;
      w_addr_nxt   = w_addr;
      b_addr_nxt   = b_addr;
      out_addr_nxt = out_addr;
      out_d_nxt    = out_d;
      in_en_nxt    = 1'b0;
      w_en_nxt     = 1'b0;
      b_en_nxt     = 1'b0;
      out_en_nxt   = 1'b0;
      out_we_nxt   = 1'b0;
      done_nxt     = 1'b0;
      busy         = (state != IDLE);
      case (state)
         IDLE: begin
            if (launch) begin
               i_nxt       = '0;
               o_nxt       = '0;
               in_addr_nxt = '0;
               w_addr_nxt  = '0;
               b_addr_nxt  = '0;
               in_en_nxt   = 1'b1;
               w_en_nxt    = 1'b1;
               b_en_nxt    = 1'b1;
            end
         end
         MAC: begin
            acc_nxt = ((i == '0) ? bias_ext : acc) + prod_ext;
            if (i != I_LAST) begin
               i_nxt       = i + 1'b1;
               in_addr_nxt = i + 1'b1;
               w_addr_nxt  = w_addr + 1'b1;
               in_en_nxt   = 1'b1;
               w_en_nxt    = 1'b1;
            end
         end
         WRITE: begin
            out_addr_nxt = o;
            out_d_nxt    = sat_val;
            out_en_nxt   = 1'b1;
            out_we_nxt   = 1'b1;
            if (o != O_LAST) begin
               o_nxt       = o + 1'b1;
               i_nxt       = '0;
               in_addr_nxt = '0;
               w_addr_nxt  = w_addr + 1'b1;
               b_addr_nxt  = o + 1'b1;
               in_en_nxt   = 1'b1;
               w_en_nxt    = 1'b1;
               b_en_nxt    = 1'b1;
            end
         end
         FINISH:  done_nxt = 1'b1;
         default: done_nxt = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         i        <= '0;
         o        <= '0;
         acc      <= '0;
         in_addr  <= '0;
         w_addr   <= '0;
         b_addr   <= '0;
         out_addr <= '0;
         out_d    <= '0;
         in_en    <= 1'b0;
         w_en     <= 1'b0;
         b_en     <= 1'b0;
         out_en   <= 1'b0;
         out_we   <= 1'b0;
         done     <= 1'b0;
      end else begin
         i        <= i_nxt;
         o        <= o_nxt;
         acc      <= acc_nxt;
         in_addr  <= in_addr_nxt;
         w_addr   <= w_addr_nxt;
         b_addr   <= b_addr_nxt;
         out_addr <= out_addr_nxt;
         out_d    <= out_d_nxt;
         in_en    <= in_en_nxt;
         w_en     <= w_en_nxt;
         b_en     <= b_en_nxt;
         out_en   <= out_en_nxt;
         out_we   <= out_we_nxt;
         done     <= done_nxt;
      end
   end

endmodule

// File: tb/tb_dense_layer.sv
// Bench for dense_layer (IN_DIM=4, OUT_DIM=3): ROM/BRAM models, event monitor, arithmetic reference model.
// Buffers present data for the request registered on the previous edge, only while its enable is high.
module tb_dense_layer;

   localparam int DW = 16;
   localparam int FB = 7;
   localparam int ID = 4;
   localparam int OD = 3;
   localparam int IW = $clog2(ID);
   localparam int WW = $clog2(ID*OD);
   localparam int OW = $clog2(OD);

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;
   logic [IW-1:0] in_addr;
   logic [WW-1:0] w_addr;
   logic [OW-1:0] b_addr, out_addr;
   logic in_en, w_en, b_en, out_en, out_we, busy, done;
   logic signed [DW-1:0] in_q, w_q, b_q, out_d;

   int in_mem [0:(1<<IW)-1];
   int w_mem  [0:(1<<WW)-1];
   int b_mem  [0:(1<<OW)-1];

   int checks = 0;
   int passes = 0;
   int edge_cnt = 0;
   int exp_l [OD];

   int wr_addr_q[$], wr_dat_q[$], wr_edge_q[$], done_edge_q[$];
   int in_log[$], w_log[$], b_log[$];
   int busy_first, busy_last, busy_cnt;

   dense_layer #(.DATA_WIDTH(DW), .FRAC_BITS(FB), .IN_DIM(ID), .OUT_DIM(OD)) dut (
      .clk(clk), .reset(reset), .start(start),
      .in_addr(in_addr), .in_en(in_en), .in_q(in_q),
      .w_addr(w_addr), .w_en(w_en), .w_q(w_q),
      .b_addr(b_addr), .b_en(b_en), .b_q(b_q),
      .out_addr(out_addr), .out_en(out_en), .out_we(out_we), .out_d(out_d),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   assign in_q = in_en ? in_mem[in_addr][DW-1:0] : '0;
   assign w_q  = w_en  ? w_mem[w_addr][DW-1:0]   : '0;
   assign b_q  = b_en  ? b_mem[b_addr][DW-1:0]   : '0;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   // At each falling edge, edge_cnt names the rising edge that produced the visible outputs.
   always @(negedge clk) begin
      if (out_we && out_en) begin
         wr_addr_q.push_back(int'(out_addr));
         wr_dat_q.push_back(int'(out_d));
         wr_edge_q.push_back(edge_cnt);
      end
      if (done) done_edge_q.push_back(edge_cnt);
      if (in_en) in_log.push_back(int'(in_addr));
      if (w_en) w_log.push_back(int'(w_addr));
      if (b_en) b_log.push_back(int'(b_addr));
      if (busy) begin
         if (busy_first < 0) busy_first = edge_cnt;
         busy_last = edge_cnt;
         busy_cnt++;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int rnd(int span);
      return int'($urandom_range(2*span, 0)) - span;
   endfunction

   function automatic int rnd_full();
      return int'($urandom_range(65535, 0)) - 32768;
   endfunction

   // Exact integer dot product, floor division by 2^FB, then clamp to the signed DW range.
   function automatic int model_logit(int o);
      longint scale, acc, q;
      scale = longint'(1) << FB;
      acc = longint'(b_mem[o]) * scale;
      for (int k = 0; k < ID; k++)
         acc += longint'(in_mem[k]) * longint'(w_mem[o*ID+k]);
      q = acc / scale;
      if ((acc % scale) != 0 && acc < 0) q = q - 1;
      if (q > 32767) q = 32767;
      if (q < -32768) q = -32768;
      return int'(q);
   endfunction

   task automatic clear_logs();
      @(posedge clk);
      #1;
      wr_addr_q.delete(); wr_dat_q.delete(); wr_edge_q.delete(); done_edge_q.delete();
      in_log.delete(); w_log.delete(); b_log.delete();
      busy_first = -1; busy_last = -1; busy_cnt = 0;
   endtask

   task automatic launch(output int e0);
      @(negedge clk);
      start = 1'b1;
      e0 = edge_cnt + 1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int n, output bit timed_out);
      timed_out = 1'b1;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (done_edge_q.size() >= n) begin
            timed_out = 1'b0;
            break;
         end
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic set_vec1();
      in_mem[0] = 128; in_mem[1] = 256; in_mem[2] = -128; in_mem[3] = 64;
      for (int k = 0; k < ID; k++) begin
         w_mem[k]      = (k == 0) ? 128 : 0;
         w_mem[ID+k]   = 128;
         w_mem[2*ID+k] = rnd(300);
      end
      b_mem[0] = 0; b_mem[1] = 128; b_mem[2] = rnd(300);
      exp_l[0] = 128; exp_l[1] = 448; exp_l[2] = model_logit(2);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({in_addr, in_en, w_addr, w_en, b_addr, b_en, out_addr, out_en, out_we, out_d, busy, done} !== '0)
         $display("FAIL reset_outputs: got %h required 0",
                  {in_addr, in_en, w_addr, w_en, b_addr, b_en, out_addr, out_en, out_we, out_d, busy, done});
      else passes++;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, done, in_en, out_we} !== 4'b0000)
         $display("FAIL idle_after_reset: busy/done/in_en/out_we got %b required 0000", {busy, done, in_en, out_we});
      else passes++;
   endtask

   task automatic test_vectors();
      int e0; bit to;
      set_vec1();
      clear_logs();
      launch(e0);
      wait_done(1, to);
      checks++; if (to !== 1'b0) $display("FAIL vec1_done: timed out"); else passes++;
      checks++;
      if (wr_dat_q.size() !== OD) $display("FAIL vec1_writes: got %0d required %0d", wr_dat_q.size(), OD);
      else passes++;
      for (int k = 0; k < OD && k < wr_dat_q.size(); k++) begin
         checks++;
         if (wr_addr_q[k] !== k) $display("FAIL vec1_addr[%0d]: got %0d required %0d", k, wr_addr_q[k], k);
         else passes++;
         checks++;
         if (wr_dat_q[k] !== exp_l[k]) $display("FAIL vec1_logit[%0d]: got %0d required %0d", k, wr_dat_q[k], exp_l[k]);
         else passes++;
      end
   endtask

   task automatic test_saturation();
      int e0; bit to;
      for (int k = 0; k < ID; k++) begin
         in_mem[k] = 32767;
         w_mem[k] = 32767;
         w_mem[ID+k] = -32768;
         w_mem[2*ID+k] = rnd_full();
      end
      b_mem[0] = 0; b_mem[1] = 0; b_mem[2] = rnd_full();
      exp_l[0] = 32767; exp_l[1] = -32768; exp_l[2] = model_logit(2);
      clear_logs();
      launch(e0);
      wait_done(1, to);
      checks++; if (to !== 1'b0) $display("FAIL sat_done: timed out"); else passes++;
      checks++;
      if (wr_dat_q.size() !== OD) $display("FAIL sat_writes: got %0d required %0d", wr_dat_q.size(), OD);
      else passes++;
      for (int k = 0; k < OD && k < wr_dat_q.size(); k++) begin
         checks++;
         if (wr_dat_q[k] !== exp_l[k]) $display("FAIL sat_logit[%0d]: got %0d required %0d", k, wr_dat_q[k], exp_l[k]);
         else passes++;
      end
   endtask

   task automatic test_floor();
      int e0; bit to;
      in_mem[0] = -1; in_mem[1] = 0; in_mem[2] = 0; in_mem[3] = 0;
      for (int k = 0; k < 2*ID; k++) w_mem[k] = rnd(2000);
      w_mem[2*ID] = 1;
      for (int k = 1; k < ID; k++) w_mem[2*ID+k] = 0;
      b_mem[0] = rnd(100); b_mem[1] = rnd(100); b_mem[2] = 0;
      exp_l[0] = model_logit(0); exp_l[1] = model_logit(1); exp_l[2] = -1;
      clear_logs();
      launch(e0);
      wait_done(1, to);
      checks++; if (to !== 1'b0) $display("FAIL floor_done: timed out"); else passes++;
      checks++;
      if (wr_dat_q.size() !== OD) $display("FAIL floor_writes: got %0d required %0d", wr_dat_q.size(), OD);
      else passes++;
      for (int k = 0; k < OD && k < wr_dat_q.size(); k++) begin
         checks++;
         if (wr_dat_q[k] !== exp_l[k]) $display("FAIL floor_logit[%0d]: got %0d required %0d", k, wr_dat_q[k], exp_l[k]);
         else passes++;
      end
   endtask

   task automatic test_timing();
      int e0, bad; bit to;
      for (int k = 0; k < ID; k++) in_mem[k] = rnd(500);
      for (int k = 0; k < ID*OD; k++) w_mem[k] = rnd(500);
      for (int k = 0; k < OD; k++) b_mem[k] = rnd(500);
      clear_logs();
      launch(e0);
      while (edge_cnt < e0 + 2) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(1, to);
      repeat (5) @(negedge clk);
      checks++; if (to !== 1'b0) $display("FAIL timing_done: timed out"); else passes++;
      checks++;
      if (wr_edge_q.size() !== OD) $display("FAIL timing_writes: got %0d required %0d", wr_edge_q.size(), OD);
      else passes++;
      for (int k = 0; k < OD && k < wr_edge_q.size(); k++) begin
         checks++;
         if (wr_edge_q[k] - e0 !== (k+1)*(ID+1))
            $display("FAIL timing_we_edge[%0d]: got E%0d required E%0d", k, wr_edge_q[k] - e0, (k+1)*(ID+1));
         else passes++;
         checks++;
         if (wr_addr_q[k] !== k) $display("FAIL timing_out_addr[%0d]: got %0d required %0d", k, wr_addr_q[k], k);
         else passes++;
      end
      checks++;
      if (done_edge_q.size() !== 1) $display("FAIL timing_done_count: got %0d required 1", done_edge_q.size());
      else passes++;
      if (done_edge_q.size() > 0) begin
         checks++;
         if (done_edge_q[0] - e0 !== OD*(ID+1)+1)
            $display("FAIL timing_done_edge: got E%0d required E%0d", done_edge_q[0] - e0, OD*(ID+1)+1);
         else passes++;
      end
      bad = (in_log.size() != ID*OD) + (w_log.size() != ID*OD) + (b_log.size() != OD);
      for (int k = 0; k < in_log.size() && k < ID*OD; k++) if (in_log[k] != k % ID) bad++;
      for (int k = 0; k < w_log.size() && k < ID*OD; k++) if (w_log[k] != k) bad++;
      for (int k = 0; k < b_log.size() && k < OD; k++) if (b_log[k] != k) bad++;
      checks++;
      if (bad !== 0) $display("FAIL timing_addr_stream: got %0d bad entries required 0", bad);
      else passes++;
      checks++;
      if (busy_first - e0 !== 0) $display("FAIL timing_busy_first: got E%0d required E0", busy_first - e0);
      else passes++;
      checks++;
      if (busy_last - e0 !== OD*(ID+1)) $display("FAIL timing_busy_last: got E%0d required E%0d", busy_last - e0, OD*(ID+1));
      else passes++;
   endtask

   task automatic test_reset_abort();
      int e0; bit to;
      set_vec1();
      clear_logs();
      launch(e0);
      for (int k = 0; k < 50 && edge_cnt < e0 + 7; k++) @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if ({in_addr, in_en, w_addr, w_en, b_addr, b_en, out_addr, out_en, out_we, out_d, busy, done} !== '0)
         $display("FAIL abort_outputs: got %h required 0",
                  {in_addr, in_en, w_addr, w_en, b_addr, b_en, out_addr, out_en, out_we, out_d, busy, done});
      else passes++;
      wr_addr_q.delete(); wr_dat_q.delete(); wr_edge_q.delete(); done_edge_q.delete();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (25) @(negedge clk);
      checks++;
      if (wr_dat_q.size() !== 0) $display("FAIL abort_no_write: got %0d writes required 0", wr_dat_q.size());
      else passes++;
      checks++;
      if (done_edge_q.size() !== 0) $display("FAIL abort_no_done: got %0d pulses required 0", done_edge_q.size());
      else passes++;
      clear_logs();
      launch(e0);
      wait_done(1, to);
      checks++; if (to !== 1'b0) $display("FAIL abort_rerun_done: timed out"); else passes++;
      checks++;
      if (wr_dat_q.size() !== OD) $display("FAIL abort_rerun_writes: got %0d required %0d", wr_dat_q.size(), OD);
      else passes++;
      for (int k = 0; k < OD && k < wr_dat_q.size(); k++) begin
         checks++;
         if (wr_dat_q[k] !== exp_l[k]) $display("FAIL abort_rerun_logit[%0d]: got %0d required %0d", k, wr_dat_q[k], exp_l[k]);
         else passes++;
      end
   endtask

   task automatic test_back_to_back();
      int e0, nw, nd; bit drained;
      for (int k = 0; k < ID; k++) in_mem[k] = rnd(3000);
      for (int k = 0; k < ID*OD; k++) w_mem[k] = rnd(3000);
      for (int k = 0; k < OD; k++) b_mem[k] = rnd(3000);
      for (int k = 0; k < OD; k++) exp_l[k] = model_logit(k);
      clear_logs();
      @(negedge clk);
      start = 1'b1;
      e0 = edge_cnt + 1;
      repeat (40) @(negedge clk);
      start = 1'b0;
      nw = wr_dat_q.size();
      nd = done_edge_q.size();
      checks++;
      if (nw !== 2*OD) $display("FAIL b2b_writes: got %0d required %0d", nw, 2*OD); else passes++;
      checks++;
      if (nd !== 2) $display("FAIL b2b_done_count: got %0d required 2", nd); else passes++;
      if (nd >= 2) begin
         checks++;
         if (done_edge_q[0] - e0 !== 16 || done_edge_q[1] - e0 !== 34)
            $display("FAIL b2b_done_edges: got E%0d,E%0d required E16,E34", done_edge_q[0] - e0, done_edge_q[1] - e0);
         else passes++;
      end
      for (int k = 0; k < nw && k < 2*OD; k++) begin
         checks++;
         if (wr_addr_q[k] !== k % OD || wr_dat_q[k] !== exp_l[k % OD])
            $display("FAIL b2b_write[%0d]: got addr %0d data %0d required addr %0d data %0d",
                     k, wr_addr_q[k], wr_dat_q[k], k % OD, exp_l[k % OD]);
         else passes++;
      end
      drained = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (!busy) begin
            drained = 1'b1;
            break;
         end
      end
      checks++;
      if (drained !== 1'b1) $display("FAIL b2b_drain: busy still high"); else passes++;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_random();
      int e0; bit to;
      for (int n = 0; n < 6; n++) begin
         for (int k = 0; k < ID; k++) in_mem[k] = (n % 2 == 0) ? rnd_full() : rnd(400);
         for (int k = 0; k < ID*OD; k++) w_mem[k] = (n % 2 == 0) ? rnd_full() : rnd(400);
         for (int k = 0; k < OD; k++) b_mem[k] = (n % 3 == 0) ? rnd_full() : rnd(200);
         for (int k = 0; k < OD; k++) exp_l[k] = model_logit(k);
         clear_logs();
         launch(e0);
         wait_done(1, to);
         checks++;
         if (to !== 1'b0 || wr_dat_q.size() !== OD)
            $display("FAIL rand%0d_pass: timeout %0d writes %0d required 0 and %0d", n, to, wr_dat_q.size(), OD);
         else passes++;
         for (int k = 0; k < OD && k < wr_dat_q.size(); k++) begin
            checks++;
            if (wr_dat_q[k] !== exp_l[k])
               $display("FAIL rand%0d_logit[%0d]: got %0d required %0d", n, k, wr_dat_q[k], exp_l[k]);
            else passes++;
         end
      end
   endtask

   initial begin
      busy_first = -1; busy_last = -1; busy_cnt = 0;
      test_reset();
      test_vectors();
      test_saturation();
      test_floor();
      test_timing();
      test_reset_abort();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
